// File: rtl/spi_master_ctrl.sv
// SPI master: sends one 10-bit {cmd,wdata} frame MSB first; rd-data frames also capture a MISO byte.
// Optional abort support is enabled by defining SPI_MASTER_ABORT_EN.
module spi_master_ctrl #(
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned IDLE_GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
`ifdef SPI_MASTER_ABORT_EN
    ,
    input  logic       abort,
    output logic       aborted
`endif
);

    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StShift,
        StTurn,
        StCapture,
        StEnd
    } state_e;

    state_e          state_q, state_d;
    logic [9:0]      frame_q, frame_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      shift_q, shift_d;
    logic            busy_q, busy_d;
    logic            ss_n_q, ss_n_d;
    logic            mosi_q, mosi_d;
    logic            done_q, done_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rdata_valid_q, rdata_valid_d;
`ifdef SPI_MASTER_ABORT_EN
    logic            aborted_q, aborted_d;
`endif

    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        bit_cnt_d     = bit_cnt_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        busy_d        = busy_q;
        ss_n_d        = ss_n_q;
        mosi_d        = mosi_q;
        done_d        = 1'b0;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
        aborted_d     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSelect;
                    frame_d = {cmd, wdata};
                    busy_d  = 1'b1;
                    ss_n_d  = 1'b0;
                    mosi_d  = cmd[1];
                end
            end
            StSelect: begin
                state_d   = StShift;
                mosi_d    = frame_q[9];
                bit_cnt_d = 4'd9;
            end
            StShift: begin
                // bit_cnt holds the index of the bit currently on MOSI; 0 means the frame is out
                if (bit_cnt_q != 4'd0) begin
                    mosi_d    = frame_q[bit_cnt_q - 4'd1];
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end else begin
                    mosi_d = 1'b0;
                    if (frame_q[9:8] == 2'b11) begin
                        bit_cnt_d = 4'd7;
                        if (TURNAROUND == 1) begin
                            state_d = StCapture;
                        end else begin
                            state_d = StTurn;
                            cnt_d   = CW'(TURNAROUND - 2);
                        end
                    end else begin
                        state_d = StEnd;
                        ss_n_d  = 1'b1;
                        done_d  = 1'b1;
                        cnt_d   = CW'(IDLE_GAP - 1);
                    end
                end
            end
            StTurn: begin
                if (cnt_q == '0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCapture: begin
                shift_d = {shift_q[5:0], MISO};
                if (bit_cnt_q == 4'd0) begin
                    rdata_d       = {shift_q, MISO};
                    rdata_valid_d = 1'b1;
                    done_d        = 1'b1;
                    ss_n_d        = 1'b1;
                    state_d       = StEnd;
                    cnt_d         = CW'(IDLE_GAP - 1);
                end else begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end
            end
            StEnd: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef SPI_MASTER_ABORT_EN
        // Abort overrides whatever the active state decided, including a completing capture
        if (abort && (state_q inside {StSelect, StShift, StTurn, StCapture})) begin
            state_d       = StEnd;
            ss_n_d        = 1'b1;
            mosi_d        = 1'b0;
            done_d        = 1'b0;
            rdata_valid_d = 1'b0;
            rdata_d       = rdata_q;
            cnt_d         = CW'(IDLE_GAP - 1);
            aborted_d     = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            frame_q       <= '0;
            bit_cnt_q     <= '0;
            cnt_q         <= '0;
            shift_q       <= '0;
            busy_q        <= 1'b0;
            ss_n_q        <= 1'b1;
            mosi_q        <= 1'b0;
            done_q        <= 1'b0;
            rdata_q       <= 8'h00;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            bit_cnt_q     <= bit_cnt_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            busy_q        <= busy_d;
            ss_n_q        <= ss_n_d;
            mosi_q        <= mosi_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

`ifdef SPI_MASTER_ABORT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign aborted = aborted_q;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign SS_n        = ss_n_q;
    assign MOSI        = mosi_q;

endmodule
